// File: rtl/hazard_control_unit_pkg.sv
// Shared hazard-unit definitions: FSM state encodings and parameter legality helpers.
package hazard_defs;

   typedef enum logic [1:0] {
      HZ_IDLE = 2'd0,
      HZ_LU   = 2'd1,
      HZ_MEMW = 2'd2
   } hz_state_e;

   localparam int LU_CYCLES_MIN = 1;
   localparam int LU_CYCLES_MAX = 4;

   // Load-use bubble count must stay inside the range the stall counter is sized for.
   function automatic bit lu_cycles_legal(input int n);
      return (n >= LU_CYCLES_MIN) && (n <= LU_CYCLES_MAX);
   endfunction

endpackage

// File: rtl/hazard_control_unit_if.sv
// Pipeline-side bundle for the hazard unit: ID/EX operand info, branch, D-cache handshake, controls.
interface hazard_control_unit_if #(
   parameter int REG_ADDR_W = 5
);
   logic                  ID_EX_MemRead_i;
   logic [REG_ADDR_W-1:0] ID_EX_RtAddr_i;
   logic [REG_ADDR_W-1:0] IF_ID_RsAddr_i;
   logic [REG_ADDR_W-1:0] IF_ID_RtAddr_i;
   logic                  IF_ID_UseRt_i;
   logic                  branch_taken_i;
   logic                  dcache_req_i;
   logic                  dcache_ack_i;
   logic                  PC_Stall_o;
   logic                  IF_ID_Stall_o;
   logic                  stall_o;
   logic                  IF_ID_Flush_o;
   logic                  mem_freeze_o;
   logic                  err_o;

   // Pipeline side: supplies stage information, consumes the control strobes.
   modport master (
      output ID_EX_MemRead_i, ID_EX_RtAddr_i, IF_ID_RsAddr_i, IF_ID_RtAddr_i,
             IF_ID_UseRt_i, branch_taken_i, dcache_req_i, dcache_ack_i,
      input  PC_Stall_o, IF_ID_Stall_o, stall_o, IF_ID_Flush_o, mem_freeze_o, err_o
   );

   // Hazard unit side.
   modport slave (
      input  ID_EX_MemRead_i, ID_EX_RtAddr_i, IF_ID_RsAddr_i, IF_ID_RtAddr_i,
             IF_ID_UseRt_i, branch_taken_i, dcache_req_i, dcache_ack_i,
      output PC_Stall_o, IF_ID_Stall_o, stall_o, IF_ID_Flush_o, mem_freeze_o, err_o
   );
endinterface

// File: rtl/hazard_control_unit_timer.sv
// hazard_timer: loadable counter that counts down to 0 or up to MAX_VAL, saturating at both ends.
module hazard_timer #(
   parameter int WIDTH   = 4,
   parameter int MAX_VAL = 15
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             load_i,
   input  logic [WIDTH-1:0] load_val_i,
   input  logic             dec_i,
   input  logic             inc_i,
   output logic [WIDTH-1:0] cnt_o
);
   localparam logic [WIDTH-1:0] MAX_C = WIDTH'(MAX_VAL);
   localparam logic [WIDTH-1:0] ONE   = WIDTH'(1);

   logic [WIDTH-1:0] cnt_q;
   logic [WIDTH-1:0] cnt_d;

   // Next count: load wins, then saturating decrement, then saturating increment.
   always_comb begin
      // NOTE: defaulting every always_comb output first keeps the block free of inferred latches.
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = load_val_i;
      end else if (dec_i) begin
         if (cnt_q != '0) cnt_d = cnt_q - ONE;
      end else if (inc_i) begin
         if (cnt_q < MAX_C) cnt_d = cnt_q + ONE;
      end
   end

   // Count register with synchronous active-low clear.
   always_ff @(posedge clk_i) begin
      // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
      if (!rst_i) cnt_q <= '0;
      else        cnt_q <= cnt_d;
   end

   assign cnt_o = cnt_q;

endmodule

// File: rtl/hazard_control_unit.sv
// Hazard control unit: load-use stall, D-cache miss freeze with watchdog, deferred branch flush.
module hazard_control_unit
   import hazard_defs::*;
#(
   parameter int REG_ADDR_W      = 5,
   parameter int LOAD_USE_CYCLES = 1,
   parameter int MISS_TIMEOUT    = 255
) (
   input logic                  clk_i,
   input logic                  rst_i,
   hazard_control_unit_if.slave hz_if
);
   localparam int LU_W   = $clog2(LOAD_USE_CYCLES + 1);
   localparam int MISS_W = $clog2(MISS_TIMEOUT + 1);
   localparam logic [LU_W-1:0]   LU_RELOAD = LU_W'(LOAD_USE_CYCLES - 1);
   localparam logic [LU_W-1:0]   LU_LAST   = LU_W'(1);
   localparam logic [MISS_W-1:0] MISS_ONE  = MISS_W'(1);
   localparam logic [MISS_W-1:0] MISS_LIM  = MISS_W'(MISS_TIMEOUT);

   if (!lu_cycles_legal(LOAD_USE_CYCLES)) begin : g_bad_lu_cycles
      $error("hazard_control_unit: LOAD_USE_CYCLES must be 1..4");
   end
   if (MISS_TIMEOUT < 1) begin : g_bad_miss_timeout
      $error("hazard_control_unit: MISS_TIMEOUT must be at least 1");
   end

   hz_state_e state_q, state_d, eff_state;
   logic      pend_q, pend_d;
   logic      err_q, err_d;

   logic              hz, miss;
   logic              lu_load, lu_dec, miss_load, miss_inc;
   logic              stall_c, freeze_c, flush_c, err_c;
   logic [LU_W-1:0]   lu_cnt;
   logic [MISS_W-1:0] miss_cnt;

   assign hz = hz_if.ID_EX_MemRead_i
             & (hz_if.ID_EX_RtAddr_i != '0)
             & ((hz_if.ID_EX_RtAddr_i == hz_if.IF_ID_RsAddr_i)
                | (hz_if.IF_ID_UseRt_i & (hz_if.ID_EX_RtAddr_i == hz_if.IF_ID_RtAddr_i)));

   assign miss = hz_if.dcache_req_i & ~hz_if.dcache_ack_i;

   // Next state and controls; the ack cycle of a miss behaves as the state being resumed.
   always_comb begin
      eff_state = state_q;
      if ((state_q == HZ_MEMW) && hz_if.dcache_ack_i)
         eff_state = (lu_cnt != '0) ? HZ_LU : HZ_IDLE;
      state_d   = eff_state;
      lu_load   = 1'b0;
      lu_dec    = 1'b0;
      miss_load = 1'b0;
      miss_inc  = 1'b0;
      stall_c   = 1'b0;
      freeze_c  = 1'b0;
      unique case (eff_state)
         HZ_IDLE: begin
            if (miss) begin
               freeze_c  = 1'b1;
               miss_load = 1'b1;
               state_d   = HZ_MEMW;
            end else if (hz) begin
               stall_c = 1'b1;
               if (LOAD_USE_CYCLES > 1) begin
                  lu_load = 1'b1;
                  state_d = HZ_LU;
               end
            end
         end
         HZ_LU: begin
            // A miss freezes without consuming a stall cycle; the count is kept for resumption.
            if (miss) begin
               freeze_c  = 1'b1;
               miss_load = 1'b1;
               state_d   = HZ_MEMW;
            end else begin
               stall_c = 1'b1;
               lu_dec  = 1'b1;
               if (lu_cnt == LU_LAST) state_d = HZ_IDLE;
            end
         end
         HZ_MEMW: begin
            freeze_c = 1'b1;
            miss_inc = 1'b1;
         end
         default: state_d = HZ_IDLE;
      endcase
   end

   // Flush arbitration and the sticky watchdog error.
   always_comb begin
      pend_d  = pend_q;
      flush_c = 1'b0;
      if (freeze_c) begin
         if (hz_if.branch_taken_i) pend_d = 1'b1;
      end else if (!stall_c) begin
         // A branch seen alongside a stall is dropped: it re-resolves once the stall lifts.
         flush_c = pend_q | hz_if.branch_taken_i;
         pend_d  = 1'b0;
      end
      err_c = (state_q == HZ_MEMW) && (miss_cnt >= MISS_LIM);
      err_d = err_q | err_c;
   end

   // State, pending-flush and error registers.
   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         state_q <= HZ_IDLE;
         pend_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         pend_q  <= pend_d;
         err_q   <= err_d;
      end
   end

   hazard_timer #(
      .WIDTH   (LU_W),
      .MAX_VAL (LOAD_USE_CYCLES)
   ) u_stall_timer (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .load_i     (lu_load),
      .load_val_i (LU_RELOAD),
      .dec_i      (lu_dec),
      .inc_i      (1'b0),
      .cnt_o      (lu_cnt)
   );

   hazard_timer #(
      .WIDTH   (MISS_W),
      .MAX_VAL (MISS_TIMEOUT)
   ) u_miss_timer (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .load_i     (miss_load),
      .load_val_i (MISS_ONE),
      .dec_i      (1'b0),
      .inc_i      (miss_inc),
      .cnt_o      (miss_cnt)
   );

   // Outputs are forced low for the whole time reset is held.
   assign hz_if.PC_Stall_o    = rst_i & stall_c;
   assign hz_if.IF_ID_Stall_o = rst_i & stall_c;
   assign hz_if.stall_o       = rst_i & stall_c;
   assign hz_if.IF_ID_Flush_o = rst_i & flush_c;
   assign hz_if.mem_freeze_o  = rst_i & freeze_c;
   assign hz_if.err_o         = rst_i & (err_q | err_c);

endmodule

// File: tb/tb_hazard_control_unit.sv
// Directed bench: dut_a (LOAD_USE_CYCLES=1, MISS_TIMEOUT=255), dut_b (LOAD_USE_CYCLES=3, MISS_TIMEOUT=8).
// Both see the same stimulus; output vectors are {PC_Stall, IF_ID_Stall, stall, Flush, freeze, err}.
module tb_hazard_control_unit;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       mem_read, use_rt, branch, req, ack;
   logic [4:0] ex_rt, id_rs, id_rt;
   int         checks = 0;
   int         errors = 0;

   always #5 clk = ~clk;

   hazard_control_unit_if #(.REG_ADDR_W(5)) bus_a ();
   hazard_control_unit_if #(.REG_ADDR_W(5)) bus_b ();

   assign bus_a.ID_EX_MemRead_i = mem_read;
   assign bus_a.ID_EX_RtAddr_i  = ex_rt;
   assign bus_a.IF_ID_RsAddr_i  = id_rs;
   assign bus_a.IF_ID_RtAddr_i  = id_rt;
   assign bus_a.IF_ID_UseRt_i   = use_rt;
   assign bus_a.branch_taken_i  = branch;
   assign bus_a.dcache_req_i    = req;
   assign bus_a.dcache_ack_i    = ack;
   assign bus_b.ID_EX_MemRead_i = mem_read;
   assign bus_b.ID_EX_RtAddr_i  = ex_rt;
   assign bus_b.IF_ID_RsAddr_i  = id_rs;
   assign bus_b.IF_ID_RtAddr_i  = id_rt;
   assign bus_b.IF_ID_UseRt_i   = use_rt;
   assign bus_b.branch_taken_i  = branch;
   assign bus_b.dcache_req_i    = req;
   assign bus_b.dcache_ack_i    = ack;

   hazard_control_unit #(.REG_ADDR_W(5), .LOAD_USE_CYCLES(1), .MISS_TIMEOUT(255)) dut_a (
      .clk_i (clk), .rst_i (rst), .hz_if (bus_a.slave)
   );
   hazard_control_unit #(.REG_ADDR_W(5), .LOAD_USE_CYCLES(3), .MISS_TIMEOUT(8)) dut_b (
      .clk_i (clk), .rst_i (rst), .hz_if (bus_b.slave)
   );

   wire [5:0] out_a = {bus_a.PC_Stall_o, bus_a.IF_ID_Stall_o, bus_a.stall_o,
                       bus_a.IF_ID_Flush_o, bus_a.mem_freeze_o, bus_a.err_o};
   wire [5:0] out_b = {bus_b.PC_Stall_o, bus_b.IF_ID_Stall_o, bus_b.stall_o,
                       bus_b.IF_ID_Flush_o, bus_b.mem_freeze_o, bus_b.err_o};

   task automatic clear_inputs();
      mem_read = 1'b0; use_rt = 1'b0; branch = 1'b0; req = 1'b0; ack = 1'b0;
      ex_rt = '0; id_rs = '0; id_rt = '0;
   endtask

   // Advance to 1 time unit after the next rising edge, where new inputs are applied.
   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_cycles(input int n);
      clear_inputs();
      for (int i = 0; i < n; i++) next_cycle();
   endtask

   task automatic test_reset();
      rst = 1'b0;
      mem_read = 1'b1; ex_rt = 5'd5; id_rs = 5'd5; branch = 1'b1; req = 1'b1;
      #2;
      checks++;
      if (out_a !== 6'b000000) begin errors++; $display("FAIL reset_hold_a: got %b want %b", out_a, 6'b000000); end
      checks++;
      if (out_b !== 6'b000000) begin errors++; $display("FAIL reset_hold_b: got %b want %b", out_b, 6'b000000); end
      next_cycle();
      rst = 1'b1;
      clear_inputs();
      #2;
      checks++;
      if (out_a !== 6'b000000) begin errors++; $display("FAIL reset_release_a: got %b want %b", out_a, 6'b000000); end
      next_cycle();
   endtask

   task automatic test_load_use_1();
      idle_cycles(2);
      mem_read = 1'b1; ex_rt = 5'd5; id_rs = 5'd5; id_rt = 5'd6; use_rt = 1'b1;
      #2;
      checks++;
      if (out_a !== 6'b111000) begin errors++; $display("FAIL lu1_stall: got %b want %b", out_a, 6'b111000); end
      next_cycle();
      mem_read = 1'b0;
      #2;
      checks++;
      if (out_a !== 6'b000000) begin errors++; $display("FAIL lu1_single_cycle: got %b want %b", out_a, 6'b000000); end
      idle_cycles(4);
      mem_read = 1'b1; ex_rt = 5'd0; id_rs = 5'd0; id_rt = 5'd0; use_rt = 1'b1;
      #2;
      checks++;
      if (out_a !== 6'b000000) begin errors++; $display("FAIL lu1_zero_reg: got %b want %b", out_a, 6'b000000); end
      checks++;
      if (out_b !== 6'b000000) begin errors++; $display("FAIL lu3_zero_reg: got %b want %b", out_b, 6'b000000); end
      next_cycle();
   endtask

   task automatic test_load_use_3();
      logic [5:0] exp;
      idle_cycles(2);
      mem_read = 1'b1; ex_rt = 5'd7; id_rs = 5'd3; id_rt = 5'd7; use_rt = 1'b0;
      #2;
      checks++;
      if (out_b !== 6'b000000) begin errors++; $display("FAIL lu3_rt_not_used: got %b want %b", out_b, 6'b000000); end
      next_cycle();
      id_rs = 5'd7;
      for (int c = 0; c < 5; c++) begin
         #2;
         exp = (c < 3) ? 6'b111000 : 6'b000000;
         checks++;
         if (out_b !== exp) begin errors++; $display("FAIL lu3_stall_cycle%0d: got %b want %b", c, out_b, exp); end
         next_cycle();
         mem_read = 1'b0;
      end
   endtask

   task automatic test_miss();
      logic [5:0] exp;
      idle_cycles(2);
      for (int c = 0; c < 6; c++) begin
         req = (c < 5);
         ack = (c == 4);
         #2;
         exp = (c < 4) ? 6'b000010 : 6'b000000;
         checks++;
         if (out_a !== exp) begin errors++; $display("FAIL miss_a_cycle%0d: got %b want %b", c, out_a, exp); end
         checks++;
         if (out_b !== exp) begin errors++; $display("FAIL miss_b_cycle%0d: got %b want %b", c, out_b, exp); end
         next_cycle();
      end
      req = 1'b1; ack = 1'b1;
      #2;
      checks++;
      if (out_a !== 6'b000000) begin errors++; $display("FAIL miss_same_cycle_ack: got %b want %b", out_a, 6'b000000); end
      next_cycle();
      clear_inputs();
      #2;
      checks++;
      if (out_a !== 6'b000000) begin errors++; $display("FAIL miss_same_cycle_after: got %b want %b", out_a, 6'b000000); end
      next_cycle();
   endtask

   task automatic test_flush();
      logic [5:0] exp;
      idle_cycles(2);
      for (int c = 0; c < 6; c++) begin
         req    = (c < 4);
         ack    = (c == 3);
         branch = (c == 1);
         #2;
         exp = (c < 3) ? 6'b000010 : ((c == 3) ? 6'b000100 : 6'b000000);
         checks++;
         if (out_a !== exp) begin errors++; $display("FAIL deferred_flush_cycle%0d: got %b want %b", c, out_a, exp); end
         next_cycle();
      end
      branch = 1'b1;
      #2;
      checks++;
      if (out_a !== 6'b000100) begin errors++; $display("FAIL direct_flush: got %b want %b", out_a, 6'b000100); end
      next_cycle();
      mem_read = 1'b1; ex_rt = 5'd5; id_rs = 5'd5;
      #2;
      checks++;
      if (out_a !== 6'b111000) begin errors++; $display("FAIL branch_with_hazard: got %b want %b", out_a, 6'b111000); end
      next_cycle();
      clear_inputs();
      #2;
      checks++;
      if (out_a !== 6'b000000) begin errors++; $display("FAIL branch_hazard_no_late_flush: got %b want %b", out_a, 6'b000000); end
      idle_cycles(4);
   endtask

   task automatic test_timeout();
      logic [5:0] exp;
      idle_cycles(2);
      for (int c = 0; c < 15; c++) begin
         req = (c < 14);
         ack = (c == 13);
         #2;
         if (c < 13) exp = (c >= 8) ? 6'b000011 : 6'b000010;
         else        exp = 6'b000001;
         checks++;
         if (out_b !== exp) begin errors++; $display("FAIL timeout_cycle%0d: got %b want %b", c, out_b, exp); end
         next_cycle();
      end
      #2;
      checks++;
      if (out_a !== 6'b000000) begin errors++; $display("FAIL timeout_a_no_err: got %b want %b", out_a, 6'b000000); end
      next_cycle();
   endtask

   task automatic test_reset_mid_stall();
      clear_inputs();
      mem_read = 1'b1; ex_rt = 5'd9; id_rs = 5'd9;
      #2;
      checks++;
      if (out_b !== 6'b111001) begin errors++; $display("FAIL rst_mid_first_stall: got %b want %b", out_b, 6'b111001); end
      next_cycle();
      mem_read = 1'b0; req = 1'b1;
      #2;
      checks++;
      if (out_b !== 6'b000011) begin errors++; $display("FAIL rst_mid_freeze_in_lu: got %b want %b", out_b, 6'b000011); end
      next_cycle();
      branch = 1'b1;
      #2;
      checks++;
      if (out_b !== 6'b000011) begin errors++; $display("FAIL rst_mid_branch_in_freeze: got %b want %b", out_b, 6'b000011); end
      next_cycle();
      branch = 1'b0; ack = 1'b1;
      #2;
      checks++;
      if (out_b !== 6'b111001) begin errors++; $display("FAIL rst_mid_resume_stall: got %b want %b", out_b, 6'b111001); end
      checks++;
      if (out_a !== 6'b000100) begin errors++; $display("FAIL rst_mid_a_pending_flush: got %b want %b", out_a, 6'b000100); end
      next_cycle();
      clear_inputs();
      rst = 1'b0;
      #2;
      checks++;
      if (out_b !== 6'b000000) begin errors++; $display("FAIL rst_mid_outputs_low: got %b want %b", out_b, 6'b000000); end
      next_cycle();
      rst = 1'b1;
      for (int c = 0; c < 3; c++) begin
         #2;
         checks++;
         if (out_b !== 6'b000000) begin errors++; $display("FAIL rst_mid_after_release%0d: got %b want %b", c, out_b, 6'b000000); end
         next_cycle();
      end
   endtask

   initial begin
      clear_inputs();
      @(posedge clk);
      #1;
      test_reset();
      test_load_use_1();
      test_load_use_3();
      test_miss();
      test_flush();
      test_timeout();
      test_reset_mid_stall();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/hazard_control_unit.md
# hazard_control_unit

Parametrised successor to the single-cycle load-use hazard detector in the 5-stage pipeline. It sits beside the ID stage and is the one source of stall, bubble, flush and freeze controls for PC, IF/ID and ID/EX. Beyond basic load-use detection it supports a configurable load-use stall length, a `$zero` exemption, and operand-use qualification so that non-readers of rt do not stall. It also handles a data-cache miss handshake that freezes the whole pipeline, with a watchdog, and defers branch flushes that arrive during a freeze.

## Interface
- `REG_ADDR_W`, 5: register address width.
- `LOAD_USE_CYCLES`, 1: bubbles inserted per load-use hazard; legal range 1..4.
- `MISS_TIMEOUT`, 255: maximum consecutive miss-wait cycles before `err_o` asserts; at least 1.

Ports:
- `clk_i`  in  1  clock; all state updates on the rising edge.
- `rst_i`  in  1  synchronous, active-low reset.
- `ID_EX_MemRead_i`  in  1  instruction in EX is a load.
- `ID_EX_RtAddr_i`  in  REG_ADDR_W  load destination register.
- `IF_ID_RsAddr_i`  in  REG_ADDR_W  rs of the instruction in ID.
- `IF_ID_RtAddr_i`  in  REG_ADDR_W  rt of the instruction in ID.
- `IF_ID_UseRt_i`  in  1  instruction in ID reads rt (R-type, store, beq).
- `branch_taken_i`  in  1  branch resolved taken in ID.
- `dcache_req_i`  in  1  MEM stage has an outstanding access.
- `dcache_ack_i`  in  1  access completes this cycle.
- `PC_Stall_o`  out  1  hold PC.
- `IF_ID_Stall_o`  out  1  hold IF/ID.
- `stall_o`  out  1  insert a bubble into ID/EX (zero the control fields).
- `IF_ID_Flush_o`  out  1  zero IF/ID.
- `mem_freeze_o`  out  1  hold every pipeline register, including EX/MEM and MEM/WB.
- `err_o`  out  1  sticky miss-timeout error.

## Operation
- **Hazard condition (combinational):** `hz = ID_EX_MemRead_i & (ID_EX_RtAddr_i != 0) & ((ID_EX_RtAddr_i == IF_ID_RsAddr_i) | (IF_ID_UseRt_i & ID_EX_RtAddr_i == IF_ID_RtAddr_i))`.
- **States:** IDLE, LU_STALL, MEM_WAIT. Reset state is IDLE.
- **IDLE:**
  - `dcache_req_i & !dcache_ack_i` → `mem_freeze_o = 1` this cycle; next state MEM_WAIT; miss counter loads 1.
  - Otherwise `hz` → `PC_Stall_o`, `IF_ID_Stall_o` and `stall_o` all 1. If `LOAD_USE_CYCLES > 1`, next state LU_STALL with the stall counter loaded to `LOAD_USE_CYCLES-1`.
- **LU_STALL:**
  - The three stall outputs stay 1.
  - The counter decrements each cycle; in the cycle the counter equals 1 the stall still asserts, and the next state is IDLE.
  - A miss arriving in LU_STALL takes priority: freeze, go to MEM_WAIT, and preserve the stall counter (resume LU_STALL after the ack if the counter is nonzero).
- **MEM_WAIT:**
  - `mem_freeze_o = 1` while `!dcache_ack_i`. In the ack cycle freeze is 0 and the next state is IDLE (or LU_STALL with a preserved count).
  - The miss counter increments every cycle and saturates. When it reaches `MISS_TIMEOUT`, `err_o` sets and stays set until reset; freeze continues.
- **Priority:** freeze > load-use stall > flush.
  - `branch_taken_i` with `hz` in the same cycle: flush is suppressed, because the branch re-resolves after the stall.
  - `branch_taken_i` while `mem_freeze_o` is 1: a pending-flush flag is set. `IF_ID_Flush_o` pulses for exactly one cycle, in the first cycle with freeze 0, then the flag clears.
  - `branch_taken_i` with no freeze and no hazard: `IF_ID_Flush_o = 1` in the same cycle.
- While `mem_freeze_o` is 1, `PC_Stall_o`, `IF_ID_Stall_o`, `stall_o` and `IF_ID_Flush_o` are all 0. Freeze alone holds every register.

## Timing
- Detection, stall, flush and freeze outputs are combinational from the inputs and the current state: zero latency, as in the existing pipeline.
- A load-use hazard produces exactly `LOAD_USE_CYCLES` consecutive stall cycles.
- A miss produces a freeze from the request cycle through the cycle before the ack.
  - An ack in the request cycle produces no freeze.
- **Reset:** while `rst_i == 0`, every output is 0. The next edge forces IDLE, clears both counters, the pending flag and `err_o`. Reset mid-stall or mid-miss aborts immediately with no residual pulse.
- The miss counter width is clog2(`MISS_TIMEOUT`+1); the stall counter width is clog2(`LOAD_USE_CYCLES`+1).

## Structure
- The shared header `hazard_defs` holds:
  - the state encodings `HZ_IDLE = 2'd0`, `HZ_LU = 2'd1`, `HZ_MEMW = 2'd2`;
  - the `LOAD_USE_CYCLES` legal-range check.
- The sub-module `hazard_timer` is a loadable down/up counter with saturation. It is instantiated twice: once for the stall counter and once for the miss counter.

## Test plan
- `LOAD_USE_CYCLES=1`: lw to $5 in EX, `add` reading $5 in ID → a 1-cycle stall on all three outputs; the same case with destination $0 → no stall.
- `LOAD_USE_CYCLES=3`, `IF_ID_UseRt_i=0`, rt matches and rs does not → no stall; rs matches → exactly 3 stall cycles, then IDLE.
- `dcache_req_i=1`, ack asserted 4 cycles later → `mem_freeze_o` high for 4 cycles and low in the ack cycle; a same-cycle ack → no freeze.
- `branch_taken_i` pulsed during a freeze → `IF_ID_Flush_o` is exactly one cycle, in the first unfrozen cycle. Branch together with a hazard → no flush.
- `MISS_TIMEOUT=8`, ack withheld for 12 cycles → `err_o` rises in the 8th wait cycle and stays high after the ack.
- Reset asserted in the middle of LU_STALL with a pending flush → all outputs 0, then IDLE with no flush pulse after release.
